// File: rtl/bcd_counter_chain.sv
// Cascaded BCD counter with per-digit moduli, up/down, wrap/saturate, clear and lap capture.
// Latency 1 cycle, all outputs registered; no backpressure, one step per enabled clock.
module bcd_counter_chain #(
  parameter int                    N_DIGITS = 6,
  parameter logic [4*N_DIGITS-1:0] MODULI   = 24'h6A6AAA,
  parameter bit                    WRAP     = 1'b1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  ena,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  lap,
  output logic [4*N_DIGITS-1:0] cnt,
  output logic [4*N_DIGITS-1:0] lap_cnt,
  output logic                  lap_valid,
  output logic                  ovf
);

  localparam int W = 4 * N_DIGITS;

  logic [N_DIGITS-1:0] at_max;
  logic [N_DIGITS-1:0] at_zero;
  logic [N_DIGITS-1:0] step_en;
  logic [W-1:0]        cnt_nxt;
  logic                at_bnd;

  // Carry/borrow enables are a pure AND prefix of per-digit terminal flags
  // decoded from the registered count, so every digit updates on the same edge.
  always_comb begin
    at_max  = '0;
    at_zero = '0;
    step_en = '0;
    cnt_nxt = cnt;
    for (int i = 0; i < N_DIGITS; i++) begin
      at_max[i]  = (cnt[4*i +: 4] == (MODULI[4*i +: 4] - 4'd1));
      at_zero[i] = (cnt[4*i +: 4] == 4'd0);
    end
    step_en[0] = 1'b1;
    for (int i = 1; i < N_DIGITS; i++) begin
      step_en[i] = step_en[i-1] & (up ? at_max[i-1] : at_zero[i-1]);
    end
    at_bnd = up ? (&at_max) : (&at_zero);
    for (int i = 0; i < N_DIGITS; i++) begin
      if (step_en[i]) begin
        if (up) begin
          cnt_nxt[4*i +: 4] = at_max[i] ? 4'd0 : (cnt[4*i +: 4] + 4'd1);
        end else begin
          cnt_nxt[4*i +: 4] = at_zero[i] ? (MODULI[4*i +: 4] - 4'd1) : (cnt[4*i +: 4] - 4'd1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt       <= '0;
      lap_cnt   <= '0;
      lap_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      lap_cnt   <= '0;
      lap_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ovf <= ena & at_bnd;
      if (lap) begin
        lap_cnt   <= cnt;
        lap_valid <= 1'b1;
      end
      // Saturating mode freezes the count on a boundary step but still flags it.
      if (ena && (WRAP || !at_bnd)) begin
        cnt <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Scoreboard bench for bcd_counter_chain: default mm:ss.cc wrapping chain plus a
// two-digit saturating instance, checked against a ripple-carry reference model.
module tb_bcd_counter_chain;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        a_ena = 0, a_up = 0, a_clr = 0, a_lap = 0;
  logic        b_ena = 0, b_up = 0, b_clr = 0, b_lap = 0;
  logic [23:0] a_cnt, a_lap_cnt;
  logic        a_lap_valid, a_ovf;
  logic [7:0]  b_cnt, b_lap_cnt;
  logic        b_lap_valid, b_ovf;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] l;
    logic        lv;
    logic        o;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_cnt[2];
  logic [31:0] m_lap[2];
  bit          m_lv[2];

  always #5 clk = ~clk;

  bcd_counter_chain u_a (
    .clk(clk), .res(res), .ena(a_ena), .up(a_up), .clr(a_clr), .lap(a_lap),
    .cnt(a_cnt), .lap_cnt(a_lap_cnt), .lap_valid(a_lap_valid), .ovf(a_ovf)
  );

  bcd_counter_chain #(.N_DIGITS(2), .MODULI(8'h6A), .WRAP(1'b0)) u_b (
    .clk(clk), .res(res), .ena(b_ena), .up(b_up), .clr(b_clr), .lap(b_lap),
    .cnt(b_cnt), .lap_cnt(b_lap_cnt), .lap_valid(b_lap_valid), .ovf(b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: ripple one digit at a time, carry survives only past terminal digits.
  task automatic model_next(input logic [31:0] v, input logic [31:0] mods, input int n,
                            input bit dir_up, output logic [31:0] r, output bit bnd);
    bit carry;
    int d, m;
    r = v;
    carry = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (carry) begin
        d = int'(r[4*i +: 4]);
        m = int'(mods[4*i +: 4]);
        if (dir_up) begin
          if (d == m - 1) d = 0;
          else begin d = d + 1; carry = 1'b0; end
        end else begin
          if (d == 0) d = m - 1;
          else begin d = d - 1; carry = 1'b0; end
        end
        r[4*i +: 4] = d[3:0];
      end
    end
    bnd = carry;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = '0;
      m_lap[s] = '0;
      m_lv[s]  = 1'b0;
    end
  endtask

  task automatic step(input bit sel, input bit e, input bit u, input bit c, input bit l);
    exp_t        x;
    logic [31:0] nv;
    bit          bnd;
    bit          wrap;
    @(negedge clk);
    if (!sel) begin a_ena = e; a_up = u; a_clr = c; a_lap = l; end
    else      begin b_ena = e; b_up = u; b_clr = c; b_lap = l; end
    wrap = !sel;
    model_next(m_cnt[sel], sel ? 32'h6A : 32'h6A6AAA, sel ? 2 : 6, u, nv, bnd);
    if (c) begin
      m_cnt[sel] = '0;
      m_lap[sel] = '0;
      m_lv[sel]  = 1'b0;
      x.o        = 1'b0;
    end else begin
      x.o = e & bnd;
      if (l) begin
        m_lap[sel] = m_cnt[sel];
        m_lv[sel]  = 1'b1;
      end
      if (e && (wrap || !bnd)) m_cnt[sel] = nv;
    end
    x.c  = m_cnt[sel];
    x.l  = m_lap[sel];
    x.lv = m_lv[sel];
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    if (!sel) begin
      check("a_cnt", {8'h0, a_cnt}, x.c);
      check("a_lap_cnt", {8'h0, a_lap_cnt}, x.l);
      check("a_lap_valid", {31'h0, a_lap_valid}, {31'h0, x.lv});
      check("a_ovf", {31'h0, a_ovf}, {31'h0, x.o});
      a_ena = 0; a_up = 0; a_clr = 0; a_lap = 0;
    end else begin
      check("b_cnt", {24'h0, b_cnt}, x.c);
      check("b_lap_cnt", {24'h0, b_lap_cnt}, x.l);
      check("b_lap_valid", {31'h0, b_lap_valid}, {31'h0, x.lv});
      check("b_ovf", {31'h0, b_ovf}, {31'h0, x.o});
      b_ena = 0; b_up = 0; b_clr = 0; b_lap = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1 res = 1'b1;
    #1;
    check("rst_cnt", {8'h0, a_cnt}, 32'h0);
    check("rst_lap_cnt", {8'h0, a_lap_cnt}, 32'h0);
    check("rst_lap_valid", {31'h0, a_lap_valid}, 32'h0);
    check("rst_ovf", {31'h0, a_ovf}, 32'h0);
    @(negedge clk);
    res = 1'b0;

    // 100 centiseconds
    for (int i = 0; i < 100; i++) step(0, 1, 1, 0, 0);
    check("up100_cnt", {8'h0, a_cnt}, 32'h000100);

    // Wrap boundaries in both directions
    step(0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    check("down_wrap_cnt", {8'h0, a_cnt}, 32'h595999);
    check("down_wrap_ovf", {31'h0, a_ovf}, 32'h1);
    step(0, 1, 0, 0, 0);
    check("down2_cnt", {8'h0, a_cnt}, 32'h595998);
    check("down2_ovf", {31'h0, a_ovf}, 32'h0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    check("up_wrap_cnt", {8'h0, a_cnt}, 32'h000000);
    check("up_wrap_ovf", {31'h0, a_ovf}, 32'h1);
    step(0, 0, 1, 0, 0);
    check("ovf_one_cycle", {31'h0, a_ovf}, 32'h0);

    // Lap capture, then clear overriding lap
    for (int i = 0; i < 123; i++) step(0, 1, 1, 0, 0);
    check("pre_lap_cnt", {8'h0, a_cnt}, 32'h000123);
    step(0, 1, 1, 0, 1);
    check("lap_cnt", {8'h0, a_lap_cnt}, 32'h000123);
    check("lap_valid", {31'h0, a_lap_valid}, 32'h1);
    check("lap_step_cnt", {8'h0, a_cnt}, 32'h000124);
    step(0, 1, 1, 1, 1);
    check("clr_cnt", {8'h0, a_cnt}, 32'h0);
    check("clr_lap_cnt", {8'h0, a_lap_cnt}, 32'h0);
    check("clr_lap_valid", {31'h0, a_lap_valid}, 32'h0);

    // Random mix of direction, enable, lap and occasional clear
    for (int i = 0; i < 250; i++) begin
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0);
    end

    // Async reset between edges
    step(0, 1, 1, 1, 0);
    for (int i = 0; i < 37; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 1);
    @(negedge clk);
    #2 res = 1'b1;
    #1;
    check("arst_cnt", {8'h0, a_cnt}, 32'h0);
    check("arst_lap_cnt", {8'h0, a_lap_cnt}, 32'h0);
    check("arst_lap_valid", {31'h0, a_lap_valid}, 32'h0);
    check("arst_ovf", {31'h0, a_ovf}, 32'h0);
    @(negedge clk);
    res = 1'b0;
    model_reset();
    step(0, 1, 1, 0, 0);
    check("resume_cnt", {8'h0, a_cnt}, 32'h000001);

    // Two-digit saturating instance
    for (int i = 0; i < 59; i++) step(1, 1, 1, 0, 0);
    check("sat_top_cnt", {24'h0, b_cnt}, 32'h59);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0);
      check("sat_hold_cnt", {24'h0, b_cnt}, 32'h59);
      check("sat_hold_ovf", {31'h0, b_ovf}, 32'h1);
    end
    step(1, 1, 0, 0, 0);
    check("sat_down_cnt", {24'h0, b_cnt}, 32'h58);
    check("sat_down_ovf", {31'h0, b_ovf}, 32'h0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    check("sat_zero_cnt", {24'h0, b_cnt}, 32'h00);
    check("sat_zero_ovf", {31'h0, b_ovf}, 32'h1);
    for (int i = 0; i < 120; i++) begin
      step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_counter_chain.md
# bcd_counter_chain

Parametrised cascaded BCD counter: N_DIGITS digits with individually configurable moduli, up/down counting, wrap or saturate at the range boundaries, synchronous clear, and a lap-capture register. It is the timing core for the stopwatch/clock display path. Its packed BCD output feeds the digit multiplexer and segment decoders directly. It supersedes the fixed six-digit mm:ss.cc chain.

## Interface
Parameters:
- N_DIGITS, 6, number of digits (1..8); digit 0 is least significant
- MODULI, 24'h6A6AAA, packed 4-bit modulus per digit; MODULI[4i+3:4i] is the modulus of digit i, legal range 2..10; the default gives mm:ss.cc (10,10,10,6,10,6 from digit 0 upward)
- WRAP, 1, 1 = wrap at range boundaries; 0 = saturate

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- res  in  1  reset; asynchronous and active-high
- ena  in  1  count-step enable; one step per cycle while high
- up  in  1  direction; 1 = increment, 0 = decrement; sampled every cycle
- clr  in  1  synchronous clear of all state
- lap  in  1  capture the current count into lap_cnt
- cnt  out  4*N_DIGITS  current count, packed BCD; digit i at [4i+3:4i]
- lap_cnt  out  4*N_DIGITS  last captured count
- lap_valid  out  1  high once a capture has occurred since the last clear or reset
- ovf  out  1  one-cycle pulse when a step is taken at a range boundary

## Operation
- Range: digit i takes values 0..MODULI[i]-1. MAX is every digit at its modulus-1. ZERO is all digits 0.
- Step, up: digit 0 increments. Digit i>0 increments when every lower digit is at its max. A digit at max that increments returns to 0.
- Step, down: digit 0 decrements. Digit i>0 decrements when every lower digit is 0. A digit at 0 that decrements goes to modulus-1.
- Carry/borrow is decoded combinationally from the registered cnt. All digits update on the same clock edge; no ripple latency between digits.
- Boundary (up at MAX, or down at ZERO) with ena=1:
  - WRAP=1: cnt goes to ZERO (up) or MAX (down), and ovf=1 for one cycle.
  - WRAP=0: cnt holds, and ovf=1 on every such enabled cycle.
- Direction changes take effect on the first cycle up is sampled. There is no pipeline flush and no lost step.
- lap=1: lap_cnt <= cnt as it stood before this edge's update, and lap_valid <= 1. Repeated laps overwrite. lap does not disturb counting.
- Priority, highest first: res, then clr, then (step and lap together).
  - clr=1: cnt, lap_cnt and lap_valid go to 0, and ovf goes to 0. This overrides ena and lap in the same cycle.
- ena=0: cnt holds and ovf=0. lap still captures.
- Digits never hold values >= their modulus. No such state is reachable from reset.

## Timing
- Reset values: cnt=0, lap_cnt=0, lap_valid=0, ovf=0, asserted immediately on res rising, independent of clk.
- Reset release mid-operation: the first step occurs on the first rising edge with res low and ena high.
- Latency: ena/up/clr/lap sampled at edge k are reflected in all outputs after edge k. Every output is registered; there is no combinational input-to-output path.
- ovf is high in exactly the cycle following the boundary step, and is never high for two cycles unless two boundary steps are consecutive (saturate mode, or a small range).
- Throughput: one step per clock at any N_DIGITS. The carry decode must close timing at 8 digits.

## Test plan
- Default params, res pulse, then 100 cycles ena=1, up=1 -> cnt=24'h000100, ovf never high.
- Default params, count up to cnt=24'h595999, one more enabled step -> cnt=24'h000000 with ovf=1 for exactly one cycle.
- Default params from reset, one step with up=0 -> cnt=24'h595999 and ovf pulse. A second down step -> 24'h595998 with ovf=0.
- N_DIGITS=2, MODULI=8'h6A, WRAP=0: 59 up steps -> cnt=8'h59. Three more enabled cycles -> cnt stays 8'h59 with ovf=1 on all three. up=0 for one step -> 8'h58 with ovf=0.
- Default params at cnt=24'h000123: assert lap for one cycle with ena=1 -> lap_cnt=24'h000123, lap_valid=1, cnt=24'h000124. Then lap and clr together -> all outputs 0.
- Assert res asynchronously between clock edges mid-count -> cnt, lap_cnt, lap_valid and ovf are 0 before the next edge. After release, the count resumes from 0.
